if_id_fetch_queue: RTL and testbench

- Small circular FIFO between the IF stage and the ID stage.
- Buffers fetched instruction words with their PC and branch-prediction bit, so that ID back-pressure or I-cache refill bubbles do not directly stall fetch.
- Provides valid/ready handshakes on both sides and a flush that discards all queued entries on a branch mispredict.

---
 rtl/if_id_fetch_queue.sv | 96 +++++++++
 tb/tb_if_id_fetch_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_queue.sv
// Circular fetch queue between IF and ID: valid/ready on both sides, synchronous flush.
// Optional zero-latency empty-queue bypass when FETCHQ_BYPASS_EN is defined.
module if_id_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    input  logic          in_pred,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic          out_pred,
    output logic [AW:0]   count
);

    typedef struct packed {
        logic        pred;
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam logic [AW:0] MAX_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

    entry_t      mem [DEPTH];
    entry_t      head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        bypass;
    logic        push;
    logic        pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

`ifdef FETCHQ_BYPASS_EN
    assign bypass = empty && in_valid && out_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    // Flush wins over both handshakes; a bypassed entry never touches storage.
    assign in_ready = !full;
    assign push     = in_valid && !full && !flush && !bypass;
    assign pop      = !empty && out_ready && !flush;
    assign count    = wr_ptr - rd_ptr;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        head      = '0;
        out_valid = 1'b0;
        if (bypass) begin
            head      = {in_pred, in_pc, in_instr};
            out_valid = 1'b1;
        end else if (!empty) begin
            head      = mem[rd_ptr[AW-1:0]];
            out_valid = 1'b1;
        end
    end

    assign out_pred  = head.pred;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {in_pred, in_pc, in_instr};
    end

    // An underflow would wrap the pointer difference above DEPTH, so one bound covers both.
    count_in_range: assert property (@(posedge clk) disable iff (rst) count <= MAX_COUNT);

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Scoreboard bench for if_id_fetch_queue; expectations adapt to FETCHQ_BYPASS_EN.
module tb_if_id_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic        pred;
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_pred;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_pred;
    logic [AW:0] count;

    entry_t sb[$];
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    if_id_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_pred   (in_pred),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_pred  (out_pred),
        .count     (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle at posedge+1, check at negedge against the scoreboard, then advance the model.
    task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                         input logic pred, input logic ordy, input logic fl);
        entry_t exp_head;
        logic   exp_valid;
        logic   byp;
        logic   do_push;
        logic   do_pop;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr;
        in_pred   = pred;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        byp       = BYPASS && (sb.size() == 0) && iv && ordy && !fl;
        exp_valid = byp || (sb.size() != 0);
        if (byp) begin
            exp_head.pred  = pred;
            exp_head.pc    = pc;
            exp_head.instr = instr;
        end else if (sb.size() != 0) begin
            exp_head = sb[0];
        end else begin
            exp_head = '0;
        end
        check("in_ready",  64'(in_ready),  64'(sb.size() < DEPTH));
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("count",     64'(count),     64'(sb.size()));
        check("out_pc",    64'(out_pc),    64'(exp_head.pc));
        check("out_instr", 64'(out_instr), 64'(exp_head.instr));
        check("out_pred",  64'(out_pred),  64'(exp_head.pred));
        if (fl) begin
            sb.delete();
        end else begin
            do_push = iv && (sb.size() < DEPTH) && !byp;
            do_pop  = (sb.size() != 0) && ordy;
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back({pred, pc, instr});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        in_pred   = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_count",     64'(count),     64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1'b0);

        // Fill to full with ID stalled, then a rejected fifth push.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'(i * 4), 32'h00000013 + 32'(i), 1'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h10, 32'h00000017, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Interleaved traffic holding occupancy at 2 while both pointers wrap.
        for (int i = 0; i < 2; i++)
            cycle(1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 2; i < 10; i++)
            cycle(1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Flush at count 3 with a simultaneous push and pop.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h200 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) idle(1'b1);

        // Empty queue with both sides ready: same-cycle with bypass, next cycle without.
        cycle(1'b1, 32'h40, 32'h0040_0013, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));

        // Asynchronous reset in the middle of operation.
        for (int i = 0; i < 4; i++) idle(1'b1);
        for (int i = 0; i < 2; i++)
            cycle(1'b1, 32'h300 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check("async_rst_count",     64'(count),     64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_out_pc",    64'(out_pc),    64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1'b1);
        cycle(1'b1, 32'h500, 32'h0000_0513, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
